// File: rtl/sejf_pkg.sv
// Shared definitions for the safe controller input path.
// Holds the repeat-FSM state encoding, the default timing constants (in ms
// ticks of clk_1ms) and a counter-width helper used by the conditioner.
package sejf_pkg;

   typedef enum logic [1:0] {
      REL  = 2'd0,
      HOLD = 2'd1,
      RPT  = 2'd2
   } rep_state_t;

   localparam int          NUM_CH       = 5;
   localparam int          DEB_MS       = 20;
   localparam int          REP_DELAY_MS = 500;
   localparam int          REP_RATE_MS  = 100;
   localparam logic [4:0]  REP_MASK_DEF = 5'b00011;

   // Counter width for a count of max_val states, never narrower than 1 bit.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Bus between the raw pin block and the conditioned-event consumers.
//   raw   : asynchronous active-high pin levels (into the conditioner)
//   level : debounced levels
//   rise  : one-cycle pulse on level 0->1
//   fall  : one-cycle pulse on level 1->0
//   press : rise, or auto-repeat pulse on repeat-enabled channels
// master drives raw and observes events; slave is the conditioner.
interface input_conditioner_if #(
   parameter int WIDTH = 5
);
   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] level;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] press;

   modport master (output raw, input level, input rise, input fall, input press);
   modport slave  (input raw, output level, output rise, output fall, output press);
endinterface

// File: rtl/debounce_ch.sv
// One input channel: 2-FF synchroniser, debounce, registered edge pulses and
// an optional auto-repeat FSM feeding press.
// Ports:
//   clk   : 1 ms clock, rising edge
//   rst   : synchronous active-low reset
//   raw   : asynchronous pin level
//   level : debounced level
//   rise  : pulse on level 0->1, coincident with the new level
//   fall  : pulse on level 1->0, coincident with the new level
//   press : rise OR repeat pulse (repeat only when REP_EN)
//
// Repeat FSM states:
//   state | meaning
//   REL   | level low (or repeat disabled), counter idle
//   HOLD  | level high, counting initial delay to first repeat
//   RPT   | repeating, counting rate interval between repeats
module debounce_ch
   import sejf_pkg::*;
#(
   parameter int DEB_CNT      = DEB_MS,
   parameter int REPEAT_DELAY = REP_DELAY_MS,
   parameter int REPEAT_RATE  = REP_RATE_MS,
   parameter bit REP_EN       = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic press
);

   localparam int DW = cnt_width(DEB_CNT + 1);
   localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
   localparam logic [DW-1:0] DEB_TC   = DW'(DEB_CNT - 1);
   localparam logic [RW-1:0] DELAY_TC = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_TC  = RW'(REPEAT_RATE - 1);

   logic          s1, s2;
   logic [DW-1:0] dcnt;
   logic          upd, rise_now, fall_now;

   rep_state_t    state, state_nxt;
   logic [RW-1:0] rcnt, rcnt_nxt;
   logic          rep_now;

   // upd marks the edge on which level takes the synchronised value.
   assign upd      = (s2 != level) && (dcnt == DEB_TC);
   assign rise_now = upd &  s2;
   assign fall_now = upd & ~s2;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         dcnt  <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         rise <= rise_now;
         fall <= fall_now;
         if (s2 == level) begin
            dcnt <= '0;
         end else if (upd) begin
            level <= s2;
            dcnt  <= '0;
         end else begin
            dcnt <= dcnt + DW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= REL;
         rcnt  <= '0;
         press <= 1'b0;
      end else begin
         state <= state_nxt;
         rcnt  <= rcnt_nxt;
         press <= rise_now | rep_now;
      end
   end

   // A release on the same edge as a terminal count wins: no repeat pulse.
   always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      rep_now   = 1'b0;
      case (state)
         REL: begin
            rcnt_nxt = '0;
            if (rise_now) state_nxt = HOLD;
         end
         HOLD: begin
            if (fall_now) begin
               state_nxt = REL;
               rcnt_nxt  = '0;
            end else if (rcnt == DELAY_TC) begin
               state_nxt = RPT;
               rcnt_nxt  = '0;
               rep_now   = 1'b1;
            end else begin
               rcnt_nxt = rcnt + RW'(1);
            end
         end
         RPT: begin
            if (fall_now) begin
               state_nxt = REL;
               rcnt_nxt  = '0;
            end else if (rcnt == RATE_TC) begin
               rcnt_nxt = '0;
               rep_now  = 1'b1;
            end else begin
               rcnt_nxt = rcnt + RW'(1);
            end
         end
         default: begin
            state_nxt = REL;
            rcnt_nxt  = '0;
         end
      endcase
      if (!REP_EN) begin
         state_nxt = REL;
         rcnt_nxt  = '0;
         rep_now   = 1'b0;
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Conditions the safe's raw buttons and door switch (a, b, lock, open,
// doorCls) into clean debounced levels and one-cycle rise/fall/press pulses
// for the decoder and master FSM. Channels selected by REP_MASK auto-repeat
// press while held.
// Ports:
//   clk : 1 ms clock (clk_1ms), rising edge
//   rst : synchronous active-low reset
//   bus : slave side of input_conditioner_if (raw in; level/rise/fall/press out)
module input_conditioner
   import sejf_pkg::*;
#(
   parameter int               WIDTH        = NUM_CH,
   parameter int               DEB_CNT      = DEB_MS,
   parameter int               REPEAT_DELAY = REP_DELAY_MS,
   parameter int               REPEAT_RATE  = REP_RATE_MS,
   parameter logic [WIDTH-1:0] REP_MASK     = WIDTH'(REP_MASK_DEF)
) (
   input  logic                clk,
   input  logic                rst,
   input_conditioner_if.slave  bus
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_ch #(
         .DEB_CNT      (DEB_CNT),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE),
         .REP_EN       (REP_MASK[i])
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .raw   (bus.raw[i]),
         .level (bus.level[i]),
         .rise  (bus.rise[i]),
         .fall  (bus.fall[i]),
         .press (bus.press[i])
      );
   end

endmodule
